// File: rtl/dual_host_regbank.sv
// rtl/dual_host_regbank.sv - two-host arbitrated config/status register bank
//
// Purpose: two hosts (A and B) share one bank of read/write config registers
// and read-only status registers through a level-sensitive 4-phase req/ack
// handshake. A two-state FSM grants one host at a time. Round-robin or fixed
// priority (A wins) arbitration is selected by ARB_MODE.
//
// Ports:
//   clk, rstb                  single clock, asynchronous active-low reset
//   ena                        gates new grants (an access in flight completes)
//   a_req / b_req              host request, held until ack then dropped
//   a_wr_rdn / b_wr_rdn        1 = write, 0 = read
//   a_addr / b_addr            register address (config, then status, then unmapped)
//   a_wdata / b_wdata          write data
//   a_ack / b_ack              access complete, held until the host drops req
//   a_rdata / b_rdata          read data, valid while ack is high, else 0
//   a_err / b_err              access error, valid while ack is high, else 0
//   config_regs                flattened config registers, reg i at [i*REG_WIDTH +: REG_WIDTH]
//   cfg_wr_strobe              one-hot, one-cycle pulse on a successful config write
//   status_regs                flattened status inputs, same packing as config_regs

module dual_host_regbank #(
    parameter int  NUM_CFG    = 8,
    parameter int  NUM_STATUS = 8,
    parameter int  REG_WIDTH  = 8,
    parameter int  ARB_MODE   = 0,
    localparam int ADDR_W     = ($clog2(NUM_CFG + NUM_STATUS) > 1) ?
                                $clog2(NUM_CFG + NUM_STATUS) : 1
) (
    input  logic                             clk,
    input  logic                             rstb,
    input  logic                             ena,

    input  logic                             a_req,
    input  logic                             a_wr_rdn,
    input  logic [ADDR_W-1:0]                a_addr,
    input  logic [REG_WIDTH-1:0]             a_wdata,
    output logic                             a_ack,
    output logic [REG_WIDTH-1:0]             a_rdata,
    output logic                             a_err,

    input  logic                             b_req,
    input  logic                             b_wr_rdn,
    input  logic [ADDR_W-1:0]                b_addr,
    input  logic [REG_WIDTH-1:0]             b_wdata,
    output logic                             b_ack,
    output logic [REG_WIDTH-1:0]             b_rdata,
    output logic                             b_err,

    output logic [NUM_CFG*REG_WIDTH-1:0]     config_regs,
    output logic [NUM_CFG-1:0]               cfg_wr_strobe,
    input  logic [NUM_STATUS*REG_WIDTH-1:0]  status_regs
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Grant owner: 0 = host A, 1 = host B. It keeps its value after the
    // access ends, so it also serves as the last-grant memory for round-robin.
    logic sel_q, sel_d;

    logic [NUM_CFG-1:0][REG_WIDTH-1:0] cfg_q, cfg_d;
    logic [NUM_CFG-1:0]                strobe_q, strobe_d;
    logic [REG_WIDTH-1:0]              rdata_q, rdata_d;
    logic                              err_q, err_d;

    logic                  commit;
    logic                  grant_b;
    logic                  acc_wr;
    logic [ADDR_W-1:0]     acc_addr;
    logic [REG_WIDTH-1:0]  acc_wdata;
    logic [NUM_CFG-1:0]    cfg_hit;
    logic                  stat_hit;
    logic [REG_WIDTH-1:0]  cfg_rd;
    logic [REG_WIDTH-1:0]  stat_rd;

    // An access is committed on the same edge that moves IDLE -> ACK.
    assign commit = (state_q == IDLE) && ena && (a_req || b_req);

    if (ARB_MODE == 1) begin : g_fixed_prio
        assign grant_b = b_req && !a_req;
    end else begin : g_round_robin
        // On contention B wins only if A held the previous grant.
        assign grant_b = b_req && (!a_req || !sel_q);
    end

    // Request fields of the host about to be granted.
    assign acc_wr    = grant_b ? b_wr_rdn : a_wr_rdn;
    assign acc_addr  = grant_b ? b_addr   : a_addr;
    assign acc_wdata = grant_b ? b_wdata  : a_wdata;

    // Address decode; loops avoid out-of-range indexing for any parameter mix.
    always_comb begin
        cfg_hit  = '0;
        stat_hit = 1'b0;
        cfg_rd   = '0;
        stat_rd  = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (acc_addr == ADDR_W'(i)) begin
                cfg_hit[i] = 1'b1;
                cfg_rd     = cfg_q[i];
            end
        end
        for (int j = 0; j < NUM_STATUS; j++) begin
            if (acc_addr == ADDR_W'(NUM_CFG + j)) begin
                stat_hit = 1'b1;
                stat_rd  = status_regs[j*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    // Access execution. Response is captured once at commit, so later address,
    // wdata or status changes cannot disturb what the host sees during ACK.
    always_comb begin
        rdata_d  = rdata_q;
        err_d    = err_q;
        cfg_d    = cfg_q;
        strobe_d = '0;
        if (commit) begin
            rdata_d = '0;
            err_d   = 1'b0;
            if (acc_wr) begin
                if (|cfg_hit) begin
                    strobe_d = cfg_hit;
                    for (int i = 0; i < NUM_CFG; i++) begin
                        if (cfg_hit[i]) begin
                            cfg_d[i] = acc_wdata;
                        end
                    end
                end else begin
                    err_d = 1'b1;
                end
            end else if (|cfg_hit) begin
                rdata_d = cfg_rd;
            end else if (stat_hit) begin
                rdata_d = stat_rd;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (commit) begin
                    state_d = ACK;
                    sel_d   = grant_b;
                end
            end
            ACK: begin
                // ena is ignored here: a granted access always completes.
                if (sel_q ? !b_req : !a_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q  <= IDLE;
            sel_q    <= 1'b1;
            cfg_q    <= '0;
            strobe_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cfg_q    <= cfg_d;
            strobe_q <= strobe_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Response outputs are gated by ack so the idle or non-granted host sees 0.
    assign a_ack   = (state_q == ACK) && !sel_q;
    assign b_ack   = (state_q == ACK) &&  sel_q;
    assign a_rdata = a_ack ? rdata_q : '0;
    assign b_rdata = b_ack ? rdata_q : '0;
    assign a_err   = a_ack && err_q;
    assign b_err   = b_ack && err_q;

    assign config_regs   = cfg_q;
    assign cfg_wr_strobe = strobe_q;

endmodule

// File: tb/tb_dual_host_regbank.sv
// tb/tb_dual_host_regbank.sv - scoreboard bench for dual_host_regbank (round-robin and fixed-priority instances)

module tb_dual_host_regbank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstb;
    logic        ena     [2];
    logic        a_req   [2];
    logic        b_req   [2];
    logic        a_wr    [2];
    logic        b_wr    [2];
    logic [3:0]  a_addr  [2];
    logic [3:0]  b_addr  [2];
    logic [7:0]  a_wdata [2];
    logic [7:0]  b_wdata [2];
    logic        a_ack   [2];
    logic        b_ack   [2];
    logic        a_err   [2];
    logic        b_err   [2];
    logic [7:0]  a_rdata [2];
    logic [7:0]  b_rdata [2];
    logic [63:0] cfg     [2];
    logic [7:0]  strobe  [2];
    logic [63:0] st0;
    logic [47:0] st1;

    // Instance 0: defaults, round-robin, all 16 addresses mapped.
    dual_host_regbank #(.NUM_CFG(8), .NUM_STATUS(8), .REG_WIDTH(8), .ARB_MODE(0)) u_rr (
        .clk(clk), .rstb(rstb), .ena(ena[0]),
        .a_req(a_req[0]), .a_wr_rdn(a_wr[0]), .a_addr(a_addr[0]), .a_wdata(a_wdata[0]),
        .a_ack(a_ack[0]), .a_rdata(a_rdata[0]), .a_err(a_err[0]),
        .b_req(b_req[0]), .b_wr_rdn(b_wr[0]), .b_addr(b_addr[0]), .b_wdata(b_wdata[0]),
        .b_ack(b_ack[0]), .b_rdata(b_rdata[0]), .b_err(b_err[0]),
        .config_regs(cfg[0]), .cfg_wr_strobe(strobe[0]), .status_regs(st0)
    );

    // Instance 1: fixed priority, 6 status regs so addresses 14 and 15 are unmapped.
    dual_host_regbank #(.NUM_CFG(8), .NUM_STATUS(6), .REG_WIDTH(8), .ARB_MODE(1)) u_fp (
        .clk(clk), .rstb(rstb), .ena(ena[1]),
        .a_req(a_req[1]), .a_wr_rdn(a_wr[1]), .a_addr(a_addr[1]), .a_wdata(a_wdata[1]),
        .a_ack(a_ack[1]), .a_rdata(a_rdata[1]), .a_err(a_err[1]),
        .b_req(b_req[1]), .b_wr_rdn(b_wr[1]), .b_addr(b_addr[1]), .b_wdata(b_wdata[1]),
        .b_ack(b_ack[1]), .b_rdata(b_rdata[1]), .b_err(b_err[1]),
        .config_regs(cfg[1]), .cfg_wr_strobe(strobe[1]), .status_regs(st1)
    );

    typedef struct {
        int         dut;
        bit         host;
        logic [7:0] rdata;
        bit         err;
    } exp_t;

    exp_t sbq [$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ack_of(input int d, input bit h);
        return h ? b_ack[d] : a_ack[d];
    endfunction

    task automatic drive(input int d, input bit h, input bit req, input bit wr,
                         input logic [3:0] addr, input logic [7:0] wd);
        if (!h) begin
            a_wr[d] = wr; a_addr[d] = addr; a_wdata[d] = wd; a_req[d] = req;
        end else begin
            b_wr[d] = wr; b_addr[d] = addr; b_wdata[d] = wd; b_req[d] = req;
        end
    endtask

    task automatic wait_ack(input int d, input bit h, input bit lvl, input string name);
        int n = 0;
        while ((ack_of(d, h) !== lvl) && (n < 100)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL %s timeout: ack still %0b, required %0b", name, ack_of(d, h), lvl);
        end
    endtask

    // Called at a negedge; returns at the negedge where ack is seen low again.
    task automatic xact(input int d, input bit h, input bit wr, input logic [3:0] addr,
                        input logic [7:0] wd, input int hold, input bit push,
                        input logic [7:0] er, input bit ee, input logic [7:0] es);
        if (push) sbq.push_back('{d, h, er, ee});
        drive(d, h, 1'b1, wr, addr, wd);
        wait_ack(d, h, 1'b1, "ack_rise");
        chk("strobe_first_ack_cycle", 64'(strobe[d]), 64'(es));
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("ack_held", 64'(ack_of(d, h)), 64'd1);
            chk("strobe_one_cycle", 64'(strobe[d]), 64'd0);
        end
        drive(d, h, 1'b0, wr, addr, wd);
        @(negedge clk);
        chk("ack_release", 64'(ack_of(d, h)), 64'd0);
    endtask

    // Monitor: every rising ack pops one expected response.
    logic pa [2] = '{1'b0, 1'b0};
    logic pb [2] = '{1'b0, 1'b0};
    always @(negedge clk) begin
        exp_t e;
        bit   h;
        for (int d = 0; d < 2; d++) begin
            if ((a_ack[d] && !pa[d]) || (b_ack[d] && !pb[d])) begin
                h = b_ack[d];
                checks++;
                if (a_ack[d] && b_ack[d]) begin
                    errors++;
                    $display("FAIL both_acks dut=%0d actual=11 required=one-hot", d);
                end
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack dut=%0d host=%0d actual=ack required=none", d, h);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_dut", 64'(d), 64'(e.dut));
                    chk("sb_grant_host", 64'(h), 64'(e.host));
                    chk("sb_rdata", 64'(h ? b_rdata[d] : a_rdata[d]), 64'(e.rdata));
                    chk("sb_err", 64'(h ? b_err[d] : a_err[d]), 64'(e.err));
                    chk("other_host_quiet",
                        h ? 64'({a_ack[d], a_err[d], a_rdata[d]}) : 64'({b_ack[d], b_err[d], b_rdata[d]}),
                        64'd0);
                end
            end
            pa[d] = a_ack[d];
            pb[d] = b_ack[d];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstb = 1'b0;
        for (int d = 0; d < 2; d++) begin
            ena[d] = 1'b1;
            drive(d, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
            drive(d, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
        end
        st0 = 64'h0;
        st0[23:16] = 8'h3C;
        st1 = 48'h5A00_0000_0000;
        repeat (3) @(negedge clk);

        chk("reset_cfg", cfg[0], 64'd0);
        chk("reset_strobe", 64'(strobe[0]), 64'd0);
        chk("reset_acks", 64'({a_ack[0], b_ack[0], a_ack[1], b_ack[1]}), 64'd0);
        chk("reset_resp", 64'({a_err[0], b_err[0], a_rdata[0], b_rdata[0]}), 64'd0);
        rstb = 1'b1;
        @(negedge clk);

        // A writes 0xA5 to config 3.
        xact(0, 1'b0, 1'b1, 4'd3, 8'hA5, 2, 1'b1, 8'h00, 1'b0, 8'h08);
        chk("cfg3_written", cfg[0], 64'h0000_0000_A500_0000);

        // B reads status word 2; status and address change during ACK.
        sbq.push_back('{0, 1'b1, 8'h3C, 1'b0});
        drive(0, 1'b1, 1'b1, 1'b0, 4'd10, 8'd0);
        wait_ack(0, 1'b1, 1'b1, "status_ack_rise");
        st0[23:16] = 8'hFF;
        b_addr[0]  = 4'd3;
        @(negedge clk);
        chk("status_snapshot_held", 64'(b_rdata[0]), 64'h3C);
        chk("status_read_err", 64'(b_err[0]), 64'd0);
        drive(0, 1'b1, 1'b0, 1'b0, 4'd3, 8'd0);
        @(negedge clk);
        chk("status_ack_release", 64'(b_ack[0]), 64'd0);

        // Error cases: write to status, unmapped read/write.
        xact(0, 1'b0, 1'b1, 4'd8, 8'h55, 1, 1'b1, 8'h00, 1'b1, 8'h00);
        chk("cfg_after_status_write", cfg[0], 64'h0000_0000_A500_0000);
        xact(1, 1'b0, 1'b0, 4'd14, 8'h00, 1, 1'b1, 8'h00, 1'b1, 8'h00);
        xact(1, 1'b0, 1'b1, 4'd15, 8'h66, 1, 1'b1, 8'h00, 1'b1, 8'h00);
        chk("cfg_after_unmapped_write", cfg[1], 64'd0);
        xact(1, 1'b1, 1'b0, 4'd13, 8'h00, 1, 1'b1, 8'h5A, 1'b0, 8'h00);

        // Round-robin: A made the last grant, so contention starts with B.
        xact(0, 1'b0, 1'b1, 4'd1, 8'h11, 1, 1'b1, 8'h00, 1'b0, 8'h02);
        xact(0, 1'b0, 1'b1, 4'd2, 8'h22, 1, 1'b1, 8'h00, 1'b0, 8'h04);
        chk("cfg_rr_setup", cfg[0], 64'h0000_0000_A522_1100);
        sbq.push_back('{0, 1'b1, 8'h22, 1'b0});
        sbq.push_back('{0, 1'b0, 8'h11, 1'b0});
        sbq.push_back('{0, 1'b1, 8'h22, 1'b0});
        sbq.push_back('{0, 1'b0, 8'h11, 1'b0});
        sbq.push_back('{0, 1'b0, 8'h11, 1'b0});
        fork
            begin
                for (int i = 0; i < 3; i++) xact(0, 1'b0, 1'b0, 4'd1, 8'h00, 1, 1'b0, 8'h00, 1'b0, 8'h00);
            end
            begin
                for (int i = 0; i < 2; i++) xact(0, 1'b1, 1'b0, 4'd2, 8'h00, 1, 1'b0, 8'h00, 1'b0, 8'h00);
            end
        join

        // Fixed priority: A wins every contested grant even though B was last.
        xact(1, 1'b0, 1'b1, 4'd1, 8'h11, 1, 1'b1, 8'h00, 1'b0, 8'h02);
        xact(1, 1'b1, 1'b1, 4'd2, 8'h22, 1, 1'b1, 8'h00, 1'b0, 8'h04);
        for (int i = 0; i < 3; i++) sbq.push_back('{1, 1'b0, 8'h11, 1'b0});
        for (int i = 0; i < 2; i++) sbq.push_back('{1, 1'b1, 8'h22, 1'b0});
        fork
            begin
                for (int i = 0; i < 3; i++) xact(1, 1'b0, 1'b0, 4'd1, 8'h00, 1, 1'b0, 8'h00, 1'b0, 8'h00);
            end
            begin
                for (int i = 0; i < 2; i++) xact(1, 1'b1, 1'b0, 4'd2, 8'h00, 1, 1'b0, 8'h00, 1'b0, 8'h00);
            end
        join

        // ena low blocks the grant; once granted, ena low does not abort.
        ena[0] = 1'b0;
        sbq.push_back('{0, 1'b0, 8'hA5, 1'b0});
        drive(0, 1'b0, 1'b1, 1'b0, 4'd3, 8'd0);
        repeat (5) begin
            @(negedge clk);
            chk("no_grant_while_ena_low", 64'(a_ack[0]), 64'd0);
        end
        ena[0] = 1'b1;
        @(negedge clk);
        chk("ack_next_cycle_after_ena", 64'(a_ack[0]), 64'd1);
        ena[0]    = 1'b0;
        a_addr[0] = 4'd10;
        @(negedge clk);
        chk("ack_kept_ena_low", 64'(a_ack[0]), 64'd1);
        chk("rdata_addr_change_ignored", 64'(a_rdata[0]), 64'hA5);
        drive(0, 1'b0, 1'b0, 1'b0, 4'd10, 8'd0);
        @(negedge clk);
        chk("ena_low_ack_release", 64'(a_ack[0]), 64'd0);
        ena[0] = 1'b1;

        // Reset in the middle of a committed write.
        sbq.push_back('{0, 1'b0, 8'h00, 1'b0});
        drive(0, 1'b0, 1'b1, 1'b1, 4'd5, 8'h77);
        wait_ack(0, 1'b0, 1'b1, "rst_write_ack_rise");
        chk("cfg5_committed", 64'(cfg[0][47:40]), 64'h77);
        #2 rstb = 1'b0;
        #1;
        chk("ack_async_clear", 64'(a_ack[0]), 64'd0);
        chk("cfg_async_clear", cfg[0], 64'd0);
        drive(0, 1'b0, 1'b0, 1'b1, 4'd5, 8'h77);
        @(negedge clk);
        rstb = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("no_ack_after_reset", 64'({a_ack[0], b_ack[0]}), 64'd0);
        end
        sbq.push_back('{0, 1'b0, 8'h00, 1'b0});
        sbq.push_back('{0, 1'b1, 8'h00, 1'b0});
        fork
            xact(0, 1'b0, 1'b0, 4'd0, 8'h00, 1, 1'b0, 8'h00, 1'b0, 8'h00);
            xact(0, 1'b1, 1'b0, 4'd0, 8'h00, 1, 1'b0, 8'h00, 1'b0, 8'h00);
        join

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
